// File: rtl/mod_pkg.sv
// Shared state encoding and default width for the sequential modulo unit.
package mod_pkg;

  localparam int MOD_WIDTH = 32;

  typedef enum logic [1:0] {
    MOD_IDLE = 2'd0,
    MOD_RUN  = 2'd1,
    MOD_DONE = 2'd2
  } mod_state_e;

endpackage

// File: rtl/mod_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into r,
// subtract the divisor if it fits.
module mod_step
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r_next
);

  logic [WIDTH:0] s;
  logic [WIDTH:0] diff;

  always_comb begin
    s    = {r, q_msb};
    diff = s - {1'b0, b};
    // r < b before the step, so the difference always fits back in WIDTH bits
    if (s >= {1'b0, b}) r_next = diff[WIDTH-1:0];
    else                r_next = s[WIDTH-1:0];
  end

endmodule

// File: rtl/mod_seq_32bit.sv
// Sequential unsigned a mod b, one quotient bit per cycle, for the ALU result mux.
//   state    | meaning
//   MOD_IDLE | waiting for start; result/div_zero hold last value
//   MOD_RUN  | WIDTH shift-subtract iterations, busy high
//   MOD_DONE | one-cycle done pulse, result valid
module mod_seq_32bit
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mod_state_e     state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] r_step;

  mod_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .q_msb  (q_q[WIDTH-1]),
    .b      (b_q),
    .r_next (r_step)
  );

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    r_d        = r_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      MOD_IDLE: begin
        if (start) begin
          if (b == '0) begin
            result_d   = a;
            div_zero_d = 1'b1;
            state_d    = MOD_DONE;
          end else begin
            q_d        = a;
            r_d        = '0;
            b_d        = b;
            cnt_d      = '0;
            div_zero_d = 1'b0;
            state_d    = MOD_RUN;
          end
        end
      end
      MOD_RUN: begin
        r_d   = r_step;
        q_d   = q_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d = r_step;
          state_d  = MOD_DONE;
        end
      end
      MOD_DONE: state_d = MOD_IDLE;
      default:  state_d = MOD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MOD_IDLE;
      q_q        <= '0;
      r_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      r_q        <= r_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == MOD_RUN);
  assign done     = (state_q == MOD_DONE);
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mod_seq_32bit.sv
// Directed bench for mod_seq_32bit: vector table plus hand sequences for
// ignored starts, mid-run reset and back-to-back operation.
module tb_mod_seq_32bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_i, b_i;
  logic        busy, done, div_zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[8];

  mod_seq_32bit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a_i),
    .b        (b_i),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is accepted on the following posedge (edge k).
  // Returns at the negedge after done has dropped, so a follow-up call is back-to-back.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input logic exp_dz);
    int n;
    int busy_cnt;
    int exp_lat;
    exp_lat  = (b == 0) ? 0 : 32;
    a_i      = a;
    b_i      = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, exp_lat);
    check({tag, " result"}, result, exp_r);
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
    check({tag, " busy_cycles"}, busy_cnt, exp_lat);
    @(negedge clk);
    check({tag, " done_low"}, {31'd0, done}, 32'd0);
    check({tag, " result_held"}, result, exp_r);
  endtask

  initial begin
    int n;
    int done_cnt;

    vecs[0] = '{32'd100,        32'd7,          32'd2,          1'b0};
    vecs[1] = '{32'd5,          32'd9,          32'd5,          1'b0};
    vecs[2] = '{32'hFFFF_FFFF,  32'h10,         32'hF,          1'b0};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
    vecs[4] = '{32'h1234,       32'd0,          32'h1234,       1'b1};
    vecs[5] = '{32'd17,         32'd5,          32'd2,          1'b0};
    vecs[6] = '{32'd0,          32'd3,          32'd0,          1'b0};
    vecs[7] = '{32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'd0,          1'b0};

    reset = 1'b1;
    start = 1'b1;
    a_i   = 32'd9;
    b_i   = 32'd0;
    repeat (2) @(negedge clk);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst div_zero", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                                      vecs[i].exp_r, vecs[i].exp_dz);

    // Starts during RUN (n=5, n=20) and during DONE must be ignored
    a_i = 32'd100; b_i = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    done_cnt = 0;
    while (n < 45) begin
      if (done) begin
        done_cnt++;
        check("ign result", result, 32'd2);
      end
      if (n == 5 || n == 20 || done) begin
        a_i = 32'd1; b_i = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("ign done_pulses", done_cnt, 1);
    check("ign result_final", result, 32'd2);
    check("ign busy_idle", {31'd0, busy}, 32'd0);

    // Reset at RUN cycle 10 abandons the op
    a_i = 32'd100; b_i = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid busy", {31'd0, busy}, 32'd0);
    check("mid done", {31'd0, done}, 32'd0);
    check("mid result", result, 32'd0);
    check("mid div_zero", {31'd0, div_zero}, 32'd0);
    do_op("post_rst", 32'd1000, 32'd33, 32'd10, 1'b0);

    // Back-to-back: second start on the first IDLE edge after done
    do_op("b2b_first", 32'd100, 32'd7, 32'd2, 1'b0);
    do_op("b2b_second", 32'd17, 32'd5, 32'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/mod_seq_32bit.md
# mod_seq_32bit

Sequential unsigned modulo unit for the MIPS ALU. It computes `a mod b` by iterative restoring shift-subtract, one bit per cycle. It sits beside the combinational bitwise units (`and_32bit`, `or_32bit`, `nor_32bit`, …) and feeds the ALU result multiplexer. The ALU control FSM starts it with a pulse and selects its output when `done` asserts.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  dividend (unsigned); sampled on the accepted start edge.
- b  input  WIDTH  divisor (unsigned); sampled on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  high for exactly one cycle (DONE state).
- result  output  WIDTH  remainder; held from DONE until the next accepted start or reset.
- div_zero  output  1  set with result when b==0; held like result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, b!=0:
  - q←a, r←0, b_reg←b, cnt←0.
  - div_zero←0; result keeps its old value until DONE.
  - Go to RUN.
- IDLE, start=1, b==0:
  - result←a, div_zero←1.
  - Go to DONE directly.
- IDLE, start=0: stay.
- RUN, each cycle:
  - s = {r, q[WIDTH-1]}, WIDTH+1 bits.
  - If s ≥ {0, b_reg}: r←s−b_reg. Otherwise r←s[WIDTH-1:0].
  - q←q<<1; cnt←cnt+1.
  - When cnt==WIDTH−1 this cycle: result←next r, go to DONE.
- DONE: done=1. Next cycle go to IDLE unconditionally.
- start outside IDLE is ignored, with no queuing. This includes start in DONE.
- Changes on a/b after acceptance have no effect.
- Arithmetic:
  - Unsigned only. r < b_reg always holds after each step, so r fits WIDTH bits.
  - The compare/subtract is WIDTH+1 bits wide to hold the shifted-in bit.
  - cnt width is $clog2(WIDTH).
- Reset, any state including mid-RUN:
  - state←IDLE.
  - busy=0, done=0, result=0, div_zero=0, internal regs 0.
  - The operation in flight is abandoned.
- Reset and start high on the same edge: reset wins; start is ignored.

## Timing
- Accepted start at edge k, b!=0:
  - busy=1 after edges k … k+WIDTH−1.
  - DONE entered at edge k+WIDTH. done=1 and result valid during the cycle after edge k+WIDTH (32 cycles for default).
  - done=0 after edge k+WIDTH+1. The unit is back in IDLE and can accept start on that edge.
- Accepted start at edge k, b==0: done=1 after edge k (1-cycle latency); busy never asserts.
- Minimum spacing between accepted starts: WIDTH+2 edges (b!=0), or 2 edges (b==0).
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.

## Structure
- Package `mod_pkg`:
  - State encoding constants: MOD_IDLE=2'd0, MOD_RUN=2'd1, MOD_DONE=2'd2.
  - Default width constant MOD_WIDTH=32.
- Sub-module `mod_step`: combinational, one restoring iteration. Inputs r, q_msb, b. Outputs r_next. Instantiated once in the RUN datapath.
- Top holds the FSM, cnt, the q/r/b_reg registers, and the result/div_zero output registers.

## Test plan
- a=100, b=7, start pulse at edge k → busy for 32 cycles; done=1 after edge k+32; result=2, div_zero=0; done low the following cycle.
- a=5, b=9 → result=5. a=0xFFFFFFFF, b=0x10 → result=0xF. a=0x80000000, b=0xFFFFFFFF → result=0x80000000.
- a=0x1234, b=0 → done=1 the cycle after the start edge; result=0x1234, div_zero=1; busy never high.
- Start re-pulsed with a=1, b=1 at cycles 5 and 20 of a running a=100, b=7 op, and during DONE → ignored; result=2; exactly one done pulse.
- Reset asserted at RUN cycle 10 → next cycle busy=0, done=0, result=0, div_zero=0. Then a=1000, b=33 → result=10 after 32 cycles.
- Back-to-back: second start on the edge after done deasserts (a=17, b=5) → accepted; result=2 with the same 32-cycle latency.
